lp_tree_deserializer: RTL and testbench

Serial-to-parallel receiver for the LP tree serializer link. It samples one bit per CLK on SERIAL_IN and aligns to word boundaries using a periodic sync word. It then delivers INPUTS_NUM-bit parallel words with a one-cycle valid strobe. It sits at the far end of the serial lane and feeds the parallel consumer logic.

---
 rtl/lp_tree_deserializer.sv | 142 ++++++++++++++
 tb/tb_lp_tree_deserializer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lp_tree_deserializer.sv
// Serial-to-parallel receiver for the LP tree link: aligns on a periodic sync word and delivers
// INPUTS_NUM-bit words with a one-cycle valid strobe. Define LP_DESER_ERR_CNT_EN to add ERR_CNT.
module lp_tree_deserializer #(
    parameter int unsigned             INPUTS_NUM   = 16,
    parameter logic [INPUTS_NUM-1:0]   SYNC_WORD    = INPUTS_NUM'(16'hA5C3),
    parameter int unsigned             SYNC_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SERIAL_IN,
    output logic [INPUTS_NUM-1:0] PAR_OUT,
    output logic                  PAR_VALID,
    output logic                  SYNC_SEEN,
    output logic                  LOCKED,
`ifdef LP_DESER_ERR_CNT_EN
    output logic [7:0]            ERR_CNT,
`endif
    output logic                  LOCK_LOST
);

    localparam int unsigned CntW = $clog2(INPUTS_NUM);
    localparam int unsigned TmoW = (SYNC_TIMEOUT == 0) ? 1 : $clog2(SYNC_TIMEOUT + 1);
    localparam logic [CntW-1:0] LastBit    = CntW'(INPUTS_NUM - 1);
    localparam logic [TmoW-1:0] TimeoutVal = TmoW'(SYNC_TIMEOUT);

    typedef enum logic [1:0] {
        StHunt,
        StConfirm,
        StLocked
    } state_e;

    state_e                state_q, state_d;
    logic [INPUTS_NUM-1:0] sr_q;
    logic [INPUTS_NUM-1:0] nsr;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TmoW-1:0]       tmo_q, tmo_d, tmo_inc;
    logic [INPUTS_NUM-1:0] par_out_q, par_out_d;
    logic                  par_valid_q, par_valid_d;
    logic                  sync_seen_q, sync_seen_d;
    logic                  lock_lost_q, lock_lost_d;
    logic                  is_sync;
    logic                  boundary;

    assign nsr      = {SERIAL_IN, sr_q[INPUTS_NUM-1:1]};
    assign is_sync  = (nsr == SYNC_WORD);
    assign boundary = (bit_cnt_q == LastBit);
    assign tmo_inc  = tmo_q + TmoW'(1);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = boundary ? '0 : bit_cnt_q + CntW'(1);
        tmo_d       = tmo_q;
        par_out_d   = par_out_q;
        par_valid_d = 1'b0;
        sync_seen_d = 1'b0;
        lock_lost_d = 1'b0;
        case (state_q)
            StHunt: begin
                // Sync found at an arbitrary bit: re-phase the word counter to it.
                if (is_sync) begin
                    state_d   = StConfirm;
                    bit_cnt_d = '0;
                end
            end
            StConfirm: begin
                if (boundary) begin
                    if (is_sync) begin
                        state_d     = StLocked;
                        sync_seen_d = 1'b1;
                        tmo_d       = '0;
                    end else begin
                        state_d = StHunt;
                    end
                end
            end
            StLocked: begin
                if (boundary) begin
                    if (is_sync) begin
                        sync_seen_d = 1'b1;
                        tmo_d       = '0;
                    end else begin
                        par_out_d   = nsr;
                        par_valid_d = 1'b1;
                        tmo_d       = tmo_inc;
                        // The timed-out word is still delivered on the same edge.
                        if (SYNC_TIMEOUT != 0 && tmo_inc == TimeoutVal) begin
                            state_d     = StHunt;
                            lock_lost_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StHunt;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StHunt;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            sync_seen_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= nsr;
            bit_cnt_q   <= bit_cnt_d;
            tmo_q       <= tmo_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            sync_seen_q <= sync_seen_d;
            lock_lost_q <= lock_lost_d;
        end
    end

`ifdef LP_DESER_ERR_CNT_EN
    logic       err_inc;
    logic [7:0] err_cnt_q;

    assign err_inc = (state_q == StConfirm && boundary && !is_sync) || lock_lost_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            err_cnt_q <= '0;
        end else if (err_inc && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

    assign PAR_OUT   = par_out_q;
    assign PAR_VALID = par_valid_q;
    assign SYNC_SEEN = sync_seen_q;
    assign LOCK_LOST = lock_lost_q;
    assign LOCKED    = (state_q == StLocked);

endmodule

// File: tb/tb_lp_tree_deserializer.sv
// Self-checking bench for lp_tree_deserializer: directed word tables, hand-written corner cases
// and random streams checked every cycle against a bit-position reference model.
module tb_lp_tree_deserializer;

    localparam int          N    = 16;
    localparam logic [15:0] SYNC = 16'hA5C3;
    localparam int          TMO  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        serial_in;
    logic [15:0] par_out;
    logic        par_valid;
    logic        sync_seen;
    logic        locked;
    logic        lock_lost;
`ifdef LP_DESER_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    lp_tree_deserializer #(
        .INPUTS_NUM  (N),
        .SYNC_WORD   (SYNC),
        .SYNC_TIMEOUT(TMO)
    ) dut (
        .CLK      (clk),
        .RESET    (reset),
        .SERIAL_IN(serial_in),
        .PAR_OUT  (par_out),
        .PAR_VALID(par_valid),
        .SYNC_SEEN(sync_seen),
        .LOCKED   (locked),
`ifdef LP_DESER_ERR_CNT_EN
        .ERR_CNT  (err_cnt),
`endif
        .LOCK_LOST(lock_lost)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: full bit history since reset; lock is an anchor bit index, and word
    // boundaries are every N bits after it.
    bit          hist[$];
    int          anchor;
    bit          confirmed;
    int          words_since_sync;
    logic [15:0] m_par;
    bit          m_valid, m_sync, m_lost;
    int          m_err;

    function automatic logic [15:0] window(input int i);
        logic [15:0] w;
        for (int k = 0; k < N; k++) begin
            int idx = i - N + 1 + k;
            w[k] = (idx >= 0) ? hist[idx] : 1'b0;
        end
        return w;
    endfunction

    task automatic model_reset();
        hist.delete();
        anchor           = -1;
        confirmed        = 1'b0;
        words_since_sync = 0;
        m_par            = '0;
        m_valid          = 1'b0;
        m_sync           = 1'b0;
        m_lost           = 1'b0;
        m_err            = 0;
    endtask

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_step(input bit b);
        int          i;
        logic [15:0] w;
        hist.push_back(b);
        i       = hist.size() - 1;
        w       = window(i);
        m_valid = 1'b0;
        m_sync  = 1'b0;
        m_lost  = 1'b0;
        if (anchor < 0) begin
            if (w == SYNC) begin
                anchor    = i;
                confirmed = 1'b0;
            end
        end else if ((i - anchor) % N == 0) begin
            if (!confirmed) begin
                if (w == SYNC) begin
                    confirmed        = 1'b1;
                    m_sync           = 1'b1;
                    words_since_sync = 0;
                end else begin
                    anchor = -1;
                    bump_err();
                end
            end else if (w == SYNC) begin
                m_sync           = 1'b1;
                words_since_sync = 0;
            end else begin
                m_par   = w;
                m_valid = 1'b1;
                words_since_sync++;
                if (words_since_sync == TMO) begin
                    m_lost    = 1'b1;
                    anchor    = -1;
                    confirmed = 1'b0;
                    bump_err();
                end
            end
        end
    endtask

    function automatic logic [31:0] dut_vec();
        logic [7:0] e;
`ifdef LP_DESER_ERR_CNT_EN
        e = err_cnt;
`else
        e = 8'h00;
`endif
        return {4'h0, par_out, par_valid, sync_seen, locked, lock_lost, e};
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [7:0] e;
        bit         lk;
`ifdef LP_DESER_ERR_CNT_EN
        e = 8'(m_err);
`else
        e = 8'h00;
`endif
        lk = (anchor >= 0) && confirmed;
        return {4'h0, m_par, m_valid, m_sync, lk, m_lost, e};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input bit b);
        serial_in = b;
        @(posedge clk);
        model_step(b);
        @(negedge clk);
        chk("model", dut_vec(), exp_vec());
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int k = 0; k < N; k++) send_bit(w[k]);
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] w;
        do w = 16'($urandom); while (w == SYNC);
        return w;
    endfunction

    // Entered and left at a falling edge; checks the asynchronous clear immediately.
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        chk("async clear", dut_vec(), 32'h0);
        repeat (3) @(negedge clk);
        chk("reset hold", dut_vec(), 32'h0);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [15:0] word;
        logic        exp_valid;
        logic        exp_sync;
        logic        exp_locked;
        logic [15:0] exp_par;
    } vec_t;

    vec_t tbl[7];

    task automatic apply_vec(input int idx);
        send_word(tbl[idx].word);
        chk("tbl valid", {31'h0, par_valid}, {31'h0, tbl[idx].exp_valid});
        chk("tbl sync", {31'h0, sync_seen}, {31'h0, tbl[idx].exp_sync});
        chk("tbl locked", {31'h0, locked}, {31'h0, tbl[idx].exp_locked});
        chk("tbl par_out", {16'h0, par_out}, {16'h0, tbl[idx].exp_par});
    endtask

    initial begin
        int          valid_cnt;
        int          sync_cnt;
        logic [15:0] last_data;
        logic [15:0] w;

        tbl[0] = '{SYNC,     1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{SYNC,     1'b0, 1'b1, 1'b1, 16'h0000};
        tbl[2] = '{16'h1234, 1'b1, 1'b0, 1'b1, 16'h1234};
        tbl[3] = '{16'hBEEF, 1'b1, 1'b0, 1'b1, 16'hBEEF};
        tbl[4] = '{SYNC,     1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[5] = '{SYNC,     1'b0, 1'b1, 1'b1, 16'h0000};
        tbl[6] = '{16'h5A5A, 1'b1, 1'b0, 1'b1, 16'h5A5A};

        reset     = 1'b0;
        serial_in = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle line stays in hunt with all outputs quiet.
        repeat (100) send_bit(1'b0);
        chk("t1 idle", dut_vec(), 32'h0);

        // Two-sync acquisition followed by two data words.
        for (int i = 0; i < 4; i++) apply_vec(i);

        // Reset in the middle of a data word, then re-acquire.
        w = 16'h0F0F;
        for (int k = 0; k < 7; k++) send_bit(w[k]);
        do_reset();
        for (int i = 4; i < 7; i++) apply_vec(i);

        // Junk, one sync, then a non-sync word: confirm fails.
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_word(SYNC);
        chk("t3 confirm locked", {31'h0, locked}, 32'h0);
        send_word(16'h1234);
        chk("t3 locked", {31'h0, locked}, 32'h0);
        chk("t3 sync", {31'h0, sync_seen}, 32'h0);
`ifdef LP_DESER_ERR_CNT_EN
        chk("t3 err_cnt", {24'h0, err_cnt}, 32'h1);
`endif

        // Timeout: TMO data words with no sync drops lock on the last one.
        do_reset();
        send_word(SYNC);
        send_word(SYNC);
        valid_cnt = 0;
        for (int k = 0; k < TMO; k++) begin
            send_word(rand_data());
            if (par_valid) valid_cnt++;
            chk("t4 lost", {31'h0, lock_lost}, {31'h0, (k == TMO - 1)});
        end
        chk("t4 valid count", valid_cnt, TMO);
        chk("t4 locked", {31'h0, locked}, 32'h0);
        send_bit(1'b0);
        chk("t4 lost pulse", {31'h0, lock_lost}, 32'h0);
`ifdef LP_DESER_ERR_CNT_EN
        chk("t4 err_cnt", {24'h0, err_cnt}, 32'h1);
`endif

        // Periodic sync keeps lock; PAR_OUT holds across sync words.
        do_reset();
        send_word(SYNC);
        send_word(SYNC);
        sync_cnt  = 0;
        last_data = 16'h0;
        for (int k = 0; k < 30; k++) begin
            if (k % 10 == 9) begin
                send_word(SYNC);
                if (sync_seen) sync_cnt++;
                chk("t5 no valid on sync", {31'h0, par_valid}, 32'h0);
                chk("t5 par hold", {16'h0, par_out}, {16'h0, last_data});
            end else begin
                last_data = rand_data();
                send_word(last_data);
                chk("t5 data", {16'h0, par_out}, {16'h0, last_data});
            end
            chk("t5 locked", {31'h0, locked}, 32'h1);
        end
        chk("t5 sync count", sync_cnt, 3);

        // Random streams against the model.
        do_reset();
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0: begin
                    int nb = $urandom_range(1, 20);
                    for (int k = 0; k < nb; k++) send_bit(1'($urandom));
                end
                1: begin
                    send_word(SYNC);
                    send_word(SYNC);
                end
                2: send_word(SYNC);
                default: send_word(rand_data());
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
